int_ack_controller: RTL

INT_ACK_CONTROLLER -- requirements
Module: int_ack_controller

---
 rtl/pic_pkg.sv | 35 +++
 rtl/pic_priority_resolver.sv | 26 ++
 rtl/int_ack_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared encodings for the interrupt acknowledge controller: config word types,
// status read selects, OCW2 commands, acknowledge FSM states.
package pic_pkg;

  localparam logic [2:0] FLAG_ICW1 = 3'd0;
  localparam logic [2:0] FLAG_ICW2 = 3'd1;
  localparam logic [2:0] FLAG_ICW3 = 3'd2;
  localparam logic [2:0] FLAG_ICW4 = 3'd3;
  localparam logic [2:0] FLAG_OCW1 = 3'd4;
  localparam logic [2:0] FLAG_OCW2 = 3'd5;
  localparam logic [2:0] FLAG_OCW3 = 3'd6;

  localparam logic [2:0] RD_IMR   = 3'b011;
  localparam logic [2:0] RD_IRR_A = 3'b001;
  localparam logic [2:0] RD_IRR_B = 3'b111;
  localparam logic [2:0] RD_ISR   = 3'b101;

  localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
  localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;
  localparam logic [2:0] OCW2_SET_PRI    = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_ACK2 = 2'd2
  } state_e;

  // 0 = highest priority; the level just above LP ranks first.
  function automatic logic [2:0] prio_rank(input logic [2:0] irq, input logic [2:0] lp);
    return irq - lp - 3'd1;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority resolver: picks the set request closest above the
// lowest-priority pointer, wrapping modulo 8.
module pic_priority_resolver (
  input  logic [7:0] req,
  input  logic [2:0] lp,
  output logic       valid,
  output logic [2:0] winner
);

  logic [2:0] idx;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    valid  = 1'b0;
    winner = 3'd0;
    idx    = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      idx = lp + 3'(i);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/int_ack_controller.sv
// 8-level interrupt controller: request/in-service/mask registers, fully nested
// priority, two-pulse acknowledge cycle returning {base, level}.
module int_ack_controller
  import pic_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       CFG_WE,
  input  logic [2:0] FLAG,
  input  logic [7:0] CFG_DATA,
  input  logic [7:0] IR,
  input  logic       INTA,
  input  logic       RD_EN,
  input  logic [2:0] RD_SEL,
  output logic       INT,
  output logic [7:0] DOUT,
  output logic       DOUT_EN
);

  state_e     state_q, state_d;
  logic [7:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, ir_prev_q, ir_prev_d;
  logic [2:0] lp_q, lp_d, w_q, w_d;
  logic [4:0] base_q, base_d;
  logic       aeoi_q, aeoi_d, ltim_q, ltim_d, init_done_q, init_done_d;
  logic       inta_prev_q, inta_prev_d, int_q, int_d, spur_q, spur_d;

  logic [7:0] cand;
  logic       req_valid, isr_valid, inta_fall, inta_rise;
  logic [2:0] req_win, isr_win, lvl;

  assign cand = irr_q & ~imr_q;

  pic_priority_resolver u_req_res (.req(cand),  .lp(lp_q), .valid(req_valid), .winner(req_win));
  pic_priority_resolver u_isr_res (.req(isr_q), .lp(lp_q), .valid(isr_valid), .winner(isr_win));

  always_comb begin
    state_d     = state_q;
    isr_d       = isr_q;
    imr_d       = imr_q;
    lp_d        = lp_q;
    w_d         = w_q;
    base_d      = base_q;
    aeoi_d      = aeoi_q;
    ltim_d      = ltim_q;
    init_done_d = init_done_q;
    spur_d      = spur_q;
    ir_prev_d   = IR;
    inta_prev_d = INTA;
    inta_fall   = inta_prev_q & ~INTA;
    inta_rise   = ~inta_prev_q & INTA;
    lvl         = CFG_DATA[2:0];
    irr_d       = ltim_q ? IR : (irr_q | (IR & ~ir_prev_q));

    // EOI uses the pre-acknowledge ISR; an ack in the same cycle is applied after.
    if (CFG_WE && FLAG == FLAG_OCW2) begin
      case (CFG_DATA[7:5])
        OCW2_NS_EOI:     if (isr_valid) isr_d[isr_win] = 1'b0;
        OCW2_SP_EOI:     isr_d[lvl] = 1'b0;
        OCW2_ROT_NS_EOI: if (isr_valid) begin
                           isr_d[isr_win] = 1'b0;
                           lp_d           = isr_win;
                         end
        OCW2_ROT_SP_EOI: begin
                           isr_d[lvl] = 1'b0;
                           lp_d       = lvl;
                         end
        OCW2_SET_PRI:    lp_d = lvl;
        default:         ;
      endcase
    end

    int_d = init_done_q && req_valid &&
            (!isr_valid || (prio_rank(req_win, lp_q) < prio_rank(isr_win, lp_q)));

    case (state_q)
      ST_IDLE: if (inta_fall) begin
        state_d = ST_ACK1;
        int_d   = 1'b0;
        if (req_valid) begin
          w_d            = req_win;
          spur_d         = 1'b0;
          isr_d[req_win] = 1'b1;
          irr_d[req_win] = 1'b0;
        end else begin
          w_d    = 3'd7;
          spur_d = 1'b1;
        end
      end
      ST_ACK1: if (inta_fall) state_d = ST_ACK2;
      ST_ACK2: if (inta_rise) begin
        state_d = ST_IDLE;
        if (aeoi_q && !spur_q) isr_d[w_q] = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (CFG_WE) begin
      case (FLAG)
        FLAG_ICW1: begin
          irr_d       = 8'h00;
          isr_d       = 8'h00;
          imr_d       = 8'h00;
          init_done_d = 1'b0;
          lp_d        = 3'd7;
          ltim_d      = CFG_DATA[3];
          state_d     = ST_IDLE;
        end
        FLAG_ICW2: begin
          base_d      = CFG_DATA[7:3];
          init_done_d = 1'b1;
        end
        FLAG_ICW4: aeoi_d = CFG_DATA[1];
        FLAG_OCW1: imr_d  = CFG_DATA;
        FLAG_ICW3, FLAG_OCW2, FLAG_OCW3: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      irr_q       <= 8'h00;
      isr_q       <= 8'h00;
      imr_q       <= 8'h00;
      ir_prev_q   <= 8'h00;
      lp_q        <= 3'd7;
      w_q         <= 3'd0;
      base_q      <= 5'd0;
      aeoi_q      <= 1'b0;
      ltim_q      <= 1'b0;
      init_done_q <= 1'b0;
      inta_prev_q <= 1'b1;
      int_q       <= 1'b0;
      spur_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      ir_prev_q   <= ir_prev_d;
      lp_q        <= lp_d;
      w_q         <= w_d;
      base_q      <= base_d;
      aeoi_q      <= aeoi_d;
      ltim_q      <= ltim_d;
      init_done_q <= init_done_d;
      inta_prev_q <= inta_prev_d;
      int_q       <= int_d;
      spur_q      <= spur_d;
    end
  end

  assign INT = int_q;

  always_comb begin
    DOUT    = 8'h00;
    DOUT_EN = 1'b0;
    if (state_q == ST_ACK2 && !INTA) begin
      DOUT    = {base_q, w_q};
      DOUT_EN = 1'b1;
    end else if (state_q == ST_IDLE && RD_EN) begin
      DOUT_EN = 1'b1;
      case (RD_SEL)
        RD_IMR:             DOUT = imr_q;
        RD_IRR_A, RD_IRR_B: DOUT = irr_q;
        RD_ISR:             DOUT = isr_q;
        default:            DOUT = 8'h00;
      endcase
    end
  end

endmodule
